// File: rtl/cp0_reg.sv
// cp0_reg: coprocessor-0 register file and exception commit unit.
// Holds BadVAddr, Count, Compare, Status, Cause and EPC. Decides
// exception, interrupt and eret at commit time, and drives the pipeline
// flush and the redirect PC.
// Optional timer (Count/Compare/TI) is enabled with macro CP0_TIMER_EN.
// Register map: 8 BadVAddr, 9 Count, 11 Compare, 12 Status, 13 Cause, 14 EPC.
module cp0_reg #(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [31:0] STATUS_RST = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_mtc0_we,
    input  logic [4:0]  i_c0_waddr,
    input  logic [31:0] i_c0_wdata,
    input  logic [4:0]  i_c0_raddr,
    input  logic [6:0]  i_except,
    input  logic        i_bd,
    input  logic        i_eret,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_badvaddr,
    input  logic [5:0]  i_int,
    output logic [31:0] o_c0_rdata,
    output logic [31:0] o_status,
    output logic [31:0] o_cause,
    output logic [31:0] o_epc,
    output logic        o_flush,
    output logic [31:0] o_new_pc,
    output logic        o_timer_int
);

    localparam logic [4:0]  REG_BADVADDR = 5'd8;
    localparam logic [4:0]  REG_COUNT    = 5'd9;
    localparam logic [4:0]  REG_COMPARE  = 5'd11;
    localparam logic [4:0]  REG_STATUS   = 5'd12;
    localparam logic [4:0]  REG_CAUSE    = 5'd13;
    localparam logic [4:0]  REG_EPC      = 5'd14;

    // Software-writable Status bits: IM[15:8], EXL[1], IE[0].
    localparam logic [31:0] STATUS_WMASK = 32'h0000_FF03;

    localparam logic [4:0]  EXC_INT  = 5'h00;
    localparam logic [4:0]  EXC_ADEL = 5'h04;
    localparam logic [4:0]  EXC_ADES = 5'h05;
    localparam logic [4:0]  EXC_SYS  = 5'h08;
    localparam logic [4:0]  EXC_BP   = 5'h09;
    localparam logic [4:0]  EXC_RI   = 5'h0A;
    localparam logic [4:0]  EXC_OV   = 5'h0C;

    logic [31:0] status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] badvaddr_q, badvaddr_d;
    logic        bd_q, bd_d;
    logic [7:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;

    logic        ti;
    logic [31:0] count_rd;
    logic [31:0] compare_rd;

    logic        int_pend;
    logic        int_take;
    logic        exc_take;
    logic        wr_en;
    logic [4:0]  exc_code;
    logic        bad_from_pc;
    logic        bad_from_addr;
    logic [31:0] cause_val;

    // An interrupt needs a real instruction (non-zero PC) to attach EPC to.
    assign int_pend = (|(ip_q & status_q[15:8])) & status_q[0] & ~status_q[1];
    assign int_take = int_pend & (i_pc != 32'd0);
    assign exc_take = int_take | (|i_except);
    // A trapping instruction must not also retire its own mtc0 write.
    assign wr_en    = i_mtc0_we & ~exc_take;

    // Select the highest-priority cause and where BadVAddr comes from.
    always_comb begin
        exc_code      = EXC_INT;
        bad_from_pc   = 1'b0;
        bad_from_addr = 1'b0;
        if (int_take) begin
            exc_code = EXC_INT;
        end else if (i_except[0]) begin
            exc_code    = EXC_ADEL;
            bad_from_pc = 1'b1;
        end else if (i_except[5]) begin
            exc_code = EXC_RI;
        end else if (i_except[6]) begin
            exc_code = EXC_OV;
        end else if (i_except[3]) begin
            exc_code = EXC_SYS;
        end else if (i_except[4]) begin
            exc_code = EXC_BP;
        end else if (i_except[1]) begin
            exc_code      = EXC_ADEL;
            bad_from_addr = 1'b1;
        end else if (i_except[2]) begin
            exc_code      = EXC_ADES;
            bad_from_addr = 1'b1;
        end
    end

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        toggle_q, toggle_d;
    logic        ti_q, ti_d;

    // Timer next state: Count ticks at half clock rate, TI is sticky until Compare is written.
    always_comb begin
        toggle_d  = ~toggle_q;
        count_d   = toggle_q ? count_q + 32'd1 : count_q;
        compare_d = compare_q;
        ti_d      = ti_q | ((count_q == compare_q) && (compare_q != 32'd0));
        if (wr_en && (i_c0_waddr == REG_COUNT)) begin
            count_d  = i_c0_wdata;
            toggle_d = 1'b0;
        end
        if (wr_en && (i_c0_waddr == REG_COMPARE)) begin
            compare_d = i_c0_wdata;
            ti_d      = 1'b0;
        end
    end

    // Timer state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q   <= 32'd0;
            compare_q <= 32'd0;
            toggle_q  <= 1'b0;
            ti_q      <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
            ti_q      <= ti_d;
        end
    end

    assign ti         = ti_q;
    assign count_rd   = count_q;
    assign compare_rd = compare_q;
`else
    assign ti         = 1'b0;
    assign count_rd   = 32'd0;
    assign compare_rd = 32'd0;
`endif

    // Next state for Status/Cause/EPC/BadVAddr: exception beats eret, both beat mtc0.
    always_comb begin
        status_d   = status_q;
        epc_d      = epc_q;
        badvaddr_d = badvaddr_q;
        bd_d       = bd_q;
        exccode_d  = exccode_q;
        ip_d       = {i_int[5] | ti, i_int[4:0], ip_q[1:0]};
        if (wr_en) begin
            case (i_c0_waddr)
                REG_STATUS: status_d  = (status_q & ~STATUS_WMASK) | (i_c0_wdata & STATUS_WMASK);
                REG_CAUSE:  ip_d[1:0] = i_c0_wdata[9:8];
                REG_EPC:    epc_d     = i_c0_wdata;
                default:    ;
            endcase
        end
        if (exc_take) begin
            exccode_d = exc_code;
            // Nested exceptions keep the original return point.
            if (!status_q[1]) begin
                epc_d = i_bd ? i_pc - 32'd4 : i_pc;
                bd_d  = i_bd;
            end
            status_d[1] = 1'b1;
            if (bad_from_pc) begin
                badvaddr_d = i_pc;
            end else if (bad_from_addr) begin
                badvaddr_d = i_badvaddr;
            end
        end else if (i_eret) begin
            status_d[1] = 1'b0;
        end
    end

    // Architectural CP0 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            status_q   <= STATUS_RST;
            epc_q      <= 32'd0;
            badvaddr_q <= 32'd0;
            bd_q       <= 1'b0;
            ip_q       <= 8'd0;
            exccode_q  <= 5'd0;
        end else begin
            status_q   <= status_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
            bd_q       <= bd_d;
            ip_q       <= ip_d;
            exccode_q  <= exccode_d;
        end
    end

    assign cause_val = {bd_q, ti, 14'd0, ip_q, 1'b0, exccode_q, 2'b00};

    // mfc0 read mux from registered state only.
    always_comb begin
        case (i_c0_raddr)
            REG_BADVADDR: o_c0_rdata = badvaddr_q;
            REG_COUNT:    o_c0_rdata = count_rd;
            REG_COMPARE:  o_c0_rdata = compare_rd;
            REG_STATUS:   o_c0_rdata = status_q;
            REG_CAUSE:    o_c0_rdata = cause_val;
            REG_EPC:      o_c0_rdata = epc_q;
            default:      o_c0_rdata = 32'd0;
        endcase
    end

    assign o_status    = status_q;
    assign o_cause     = cause_val;
    assign o_epc       = epc_q;
    // Flush drops together with reset so a reset pipeline is never redirected.
    assign o_flush     = (exc_take | i_eret) & ~reset;
    assign o_new_pc    = exc_take ? EXC_VECTOR : epc_q;
    assign o_timer_int = ti;

endmodule

// File: tb/tb_cp0_reg.sv
// tb_cp0_reg: directed self-checking bench for cp0_reg.
// Timer checks run when CP0_TIMER_EN is defined; otherwise the disabled
// timer behaviour is checked instead.
module tb_cp0_reg;

    localparam logic [31:0] VEC = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_mtc0_we;
    logic [4:0]  i_c0_waddr;
    logic [31:0] i_c0_wdata;
    logic [4:0]  i_c0_raddr;
    logic [6:0]  i_except;
    logic        i_bd;
    logic        i_eret;
    logic [31:0] i_pc;
    logic [31:0] i_badvaddr;
    logic [5:0]  i_int;
    logic [31:0] o_c0_rdata;
    logic [31:0] o_status;
    logic [31:0] o_cause;
    logic [31:0] o_epc;
    logic        o_flush;
    logic [31:0] o_new_pc;
    logic        o_timer_int;

    int total = 0;
    int bad   = 0;

    cp0_reg #(.EXC_VECTOR(VEC), .STATUS_RST(32'h0040_0000)) dut (
        .clk(clk), .reset(reset),
        .i_mtc0_we(i_mtc0_we), .i_c0_waddr(i_c0_waddr), .i_c0_wdata(i_c0_wdata),
        .i_c0_raddr(i_c0_raddr), .i_except(i_except), .i_bd(i_bd), .i_eret(i_eret),
        .i_pc(i_pc), .i_badvaddr(i_badvaddr), .i_int(i_int),
        .o_c0_rdata(o_c0_rdata), .o_status(o_status), .o_cause(o_cause), .o_epc(o_epc),
        .o_flush(o_flush), .o_new_pc(o_new_pc), .o_timer_int(o_timer_int)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_mtc0_we  = 1'b0;
        i_c0_waddr = 5'd0;
        i_c0_wdata = 32'd0;
        i_except   = 7'd0;
        i_bd       = 1'b0;
        i_eret     = 1'b0;
        i_pc       = 32'd0;
        i_badvaddr = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        i_mtc0_we  = 1'b1;
        i_c0_waddr = a;
        i_c0_wdata = d;
        tick();
        i_mtc0_we  = 1'b0;
    endtask

    initial begin
        idle();
        i_int      = 6'd0;
        i_c0_raddr = 5'd0;
        reset      = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        $display("reset: status=%h cause=%h epc=%h", o_status, o_cause, o_epc);
        chk("rst_status", o_status, 32'h0040_0000);
        chk("rst_cause", o_cause, 32'd0);
        chk("rst_epc", o_epc, 32'd0);
        chk("rst_flush", {31'd0, o_flush}, 32'd0);
        chk("rst_tint", {31'd0, o_timer_int}, 32'd0);

        // Syscall at 0xBFC0_0100
        i_except = 7'h08; i_pc = 32'hBFC0_0100; #1;
        $display("syscall: flush=%b new_pc=%h", o_flush, o_new_pc);
        chk("sys_flush", {31'd0, o_flush}, 32'd1);
        chk("sys_newpc", o_new_pc, VEC);
        tick(); idle(); #1;
        chk("sys_epc", o_epc, 32'hBFC0_0100);
        chk("sys_cause", o_cause, 32'h0000_0020);
        chk("sys_status", o_status, 32'h0040_0002);

        // eret back from syscall
        i_eret = 1'b1; #1;
        $display("eret1: flush=%b new_pc=%h", o_flush, o_new_pc);
        chk("eret1_newpc", o_new_pc, 32'hBFC0_0100);
        tick(); idle(); #1;
        chk("eret1_status", o_status, 32'h0040_0000);

        // Overflow in delay slot
        i_except = 7'h40; i_bd = 1'b1; i_pc = 32'h8000_0014;
        tick(); idle(); #1;
        $display("ov_bd: epc=%h cause=%h", o_epc, o_cause);
        chk("ov_epc", o_epc, 32'h8000_0010);
        chk("ov_cause", o_cause, 32'h8000_0030);

        // Nested Break with EXL=1: EPC and BD hold
        i_except = 7'h10; i_pc = 32'h8000_0100; #1;
        chk("nest_newpc", o_new_pc, VEC);
        tick(); idle(); #1;
        $display("nested: epc=%h cause=%h", o_epc, o_cause);
        chk("nest_epc", o_epc, 32'h8000_0010);
        chk("nest_cause", o_cause, 32'h8000_0024);

        // eret to a software-written EPC
        mtc0(5'd14, 32'h8000_0040);
        i_c0_raddr = 5'd14; #1;
        chk("mfc0_epc", o_c0_rdata, 32'h8000_0040);
        i_eret = 1'b1; #1;
        $display("eret2: flush=%b new_pc=%h", o_flush, o_new_pc);
        chk("eret2_flush", {31'd0, o_flush}, 32'd1);
        chk("eret2_newpc", o_new_pc, 32'h8000_0040);
        tick(); idle(); #1;
        chk("eret2_status", o_status, 32'h0040_0000);

        // mtc0 Status together with AdES: write dropped
        i_mtc0_we = 1'b1; i_c0_waddr = 5'd12; i_c0_wdata = 32'h0000_FF01;
        i_except = 7'h04; i_badvaddr = 32'h8000_0003; i_pc = 32'h8000_0200; #1;
        chk("ades_flush", {31'd0, o_flush}, 32'd1);
        tick(); idle(); #1;
        i_c0_raddr = 5'd8; #1;
        $display("ades: status=%h cause=%h badv=%h", o_status, o_cause, o_c0_rdata);
        chk("ades_status", o_status, 32'h0040_0002);
        chk("ades_badv", o_c0_rdata, 32'h8000_0003);
        chk("ades_cause", o_cause, 32'h0000_0014);
        chk("ades_epc", o_epc, 32'h8000_0200);

        // Priority: fetch AdEL over RI; BadVAddr from PC
        i_except = 7'h21; i_pc = 32'h8000_0301; i_badvaddr = 32'h1111_1111;
        tick(); idle(); #1;
        chk("pri_adel_cause", o_cause, 32'h0000_0010);
        chk("pri_adel_badv", o_c0_rdata, 32'h8000_0301);
        chk("pri_adel_epc", o_epc, 32'h8000_0200);
        // Priority: RI over Ov
        i_except = 7'h60; i_pc = 32'h8000_0400;
        tick(); idle(); #1;
        chk("pri_ri_cause", o_cause, 32'h0000_0028);

        // Unmapped read, Cause IP writes and hardware sampling
        i_c0_raddr = 5'd3; #1;
        chk("mfc0_unmapped", o_c0_rdata, 32'd0);
        mtc0(5'd13, 32'hFFFF_FFFF); #1;
        chk("cause_swip", o_cause, 32'h0000_0328);
        i_int = 6'h3F;
        tick(); #1;
        chk("cause_hwip", o_cause, 32'h0000_FF28);
        i_int = 6'h00;
        tick(); #1;
        chk("cause_hwip_clr", o_cause, 32'h0000_0328);
        mtc0(5'd13, 32'd0);
        i_eret = 1'b1;
        tick(); idle(); #1;
        chk("eret3_status", o_status, 32'h0040_0000);

        // Software interrupt: taken only with a non-zero PC
        mtc0(5'd12, 32'h0000_0101);
        mtc0(5'd13, 32'h0000_0100); #1;
        chk("swint_bubble", {31'd0, o_flush}, 32'd0);
        i_pc = 32'h8000_0500; #1;
        $display("swint: flush=%b new_pc=%h", o_flush, o_new_pc);
        chk("swint_flush", {31'd0, o_flush}, 32'd1);
        chk("swint_newpc", o_new_pc, VEC);
        tick(); idle(); #1;
        chk("swint_cause", o_cause, 32'h0000_0100);
        chk("swint_epc", o_epc, 32'h8000_0500);
        chk("swint_status", o_status, 32'h0040_0103);

        // Asynchronous reset mid-cycle with an exception pending
        i_except = 7'h08; i_pc = 32'h8000_0600;
        #2 reset = 1'b1;
        #1;
        $display("midreset: status=%h cause=%h epc=%h flush=%b", o_status, o_cause, o_epc, o_flush);
        chk("mrst_status", o_status, 32'h0040_0000);
        chk("mrst_cause", o_cause, 32'd0);
        chk("mrst_epc", o_epc, 32'd0);
        chk("mrst_flush", {31'd0, o_flush}, 32'd0);
        idle();
        tick();
        reset = 1'b0;
        #1;

`ifdef CP0_TIMER_EN
        // Timer: Compare=5, IM7+IE, then restart Count at 0
        mtc0(5'd11, 32'd5);
        mtc0(5'd12, 32'h0000_8001);
        mtc0(5'd9, 32'd0);
        for (int i = 0; i < 10; i++) tick();
        chk("tmr_before", {31'd0, o_timer_int}, 32'd0);
        tick();
        $display("timer: tint=%b cause=%h", o_timer_int, o_cause);
        chk("tmr_fire", {31'd0, o_timer_int}, 32'd1);
        tick(); #1;
        chk("tmr_ip7", {31'd0, o_cause[15]}, 32'd1);
        chk("tmr_bubble", {31'd0, o_flush}, 32'd0);
        i_pc = 32'h8000_0700; #1;
        chk("tmr_flush", {31'd0, o_flush}, 32'd1);
        tick(); idle(); #1;
        chk("tmr_cause", o_cause, 32'h4000_8000);
        chk("tmr_epc", o_epc, 32'h8000_0700);
        mtc0(5'd11, 32'h0000_1000); #1;
        chk("tmr_clear", {31'd0, o_timer_int}, 32'd0);
`else
        // Timer absent: Count/Compare read 0 and never interrupt
        mtc0(5'd9, 32'h0000_1234);
        mtc0(5'd11, 32'd1);
        i_c0_raddr = 5'd9; #1;
        chk("notmr_count", o_c0_rdata, 32'd0);
        i_c0_raddr = 5'd11; #1;
        chk("notmr_compare", o_c0_rdata, 32'd0);
        for (int i = 0; i < 12; i++) tick();
        chk("notmr_tint", {31'd0, o_timer_int}, 32'd0);
        chk("notmr_cause", o_cause, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cp0_reg.md
Name: cp0_reg

Overview:
- Coprocessor-0 register file and exception commit unit.
- Sits at the write-back end of the MEM/WB pipeline register and consumes its CP0-side fields: mtc0 write, except vector, BD, eret and PC.
- Holds BadVAddr, Count, Compare, Status, Cause and EPC.
- Decides exception/interrupt/eret at commit, and drives the pipeline flush and the redirect PC.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception entry PC.
- STATUS_RST, 32'h0040_0000, Status reset value (BEV=1).

Ports:
- clk  in  1  clock
- reset  in  1  reset; one clock; asynchronous, active-high
- i_mtc0_we  in  1  CP0 write enable from MEM/WB
- i_c0_waddr  in  5  CP0 write register number
- i_c0_wdata  in  32  CP0 write data
- i_c0_raddr  in  5  CP0 read register number (mfc0)
- i_except  in  7  one-hot: [0] AdEL fetch, [1] AdEL load, [2] AdES, [3] Syscall, [4] Break, [5] RI, [6] Ov
- i_bd  in  1  committing instruction is in a delay slot
- i_eret  in  1  committing instruction is eret
- i_pc  in  32  committing instruction PC; 0 = bubble
- i_badvaddr  in  32  data address for AdEL load / AdES
- i_int  in  6  hardware interrupt lines
- o_c0_rdata  out  32  read data
- o_status, o_cause, o_epc  out  32 each  register values
- o_flush  out  1  flush the whole pipeline
- o_new_pc  out  32  redirect target, valid when o_flush=1
- o_timer_int  out  1  timer interrupt pending

Behaviour:
- Reset values:
  - Status=STATUS_RST; all other registers 0.
  - Timer toggle 0; o_timer_int 0; o_flush 0.
- Writable fields:
  - Status: IM[15:8], EXL[1], IE[0]; all other Status bits are read-only.
  - Cause: IP[9:8] only. Read-only Cause fields: BD[31], TI[30], IP[15:10], ExcCode[6:2].
- Interrupt sampling:
  - Cause.IP[15:10] <= {i_int[5] | TI, i_int[4:0]} every cycle.
- Interrupt pending:
  - int_pend = |(Cause.IP & Status.IM) & Status.IE & ~Status.EXL.
  - Evaluated against current register values.
  - An interrupt is taken only when i_pc != 0.
- Exception priority:
  - Order: interrupt > AdEL fetch > RI > Ov > Syscall > Break > AdEL load > AdES.
  - ExcCode: Int 0x00, AdEL 0x04, AdES 0x05, Sys 0x08, Bp 0x09, RI 0x0A, Ov 0x0C.
- Commit decision (combinational, same cycle):
  - exc_take = int_pend&(i_pc!=0) | (|i_except).
  - o_flush = exc_take | i_eret.
  - o_new_pc = EXC_VECTOR if exc_take, else EPC.
- On exc_take, at the next edge:
  - Cause.ExcCode is written.
  - If EXL=0: EPC = i_bd ? i_pc-4 : i_pc, and Cause.BD = i_bd. If EXL=1: EPC and BD hold.
  - EXL is set to 1.
  - BadVAddr = i_pc for fetch AdEL; BadVAddr = i_badvaddr for load AdEL / AdES.
  - The mtc0 write of the same instruction is suppressed.
- eret: at the next edge EXL <= 0. exc_take takes priority over eret if both are present.
- mtc0 write: applied at the next edge when i_mtc0_we & ~exc_take.
- mfc0 read: combinational from the registered state; no same-cycle write bypass. Unmapped registers read 0.
- Timer:
  - Toggle flips every cycle; Count += 1 when toggle=1 (half clock rate). Count wraps from 0xFFFF_FFFF to 0.
  - TI is set when Count==Compare and Compare!=0.
  - Writing Compare clears TI.
  - Writing Count loads the value and clears the toggle.
  - o_timer_int = TI.
- Asynchronous reset mid-operation returns all state to reset values immediately; o_flush deasserts with it.

Optional Feature:
- Macro: CP0_TIMER_EN.
- Defined: Count, Compare, TI and the timer behaviour exist as above.
- Undefined:
  - Count/Compare are not instantiated and read 0; writes to them are ignored.
  - TI=0 and o_timer_int=0.
  - Cause.IP[15] = i_int[5] only.

Test Plan:
- Reset asserted mid-run → Status=0x0040_0000, Cause=EPC=0, o_flush=0 immediately.
- Syscall: i_except=7'h08, i_pc=0xBFC0_0100, i_bd=0 → o_flush=1, o_new_pc=0xBFC0_0380; next cycle EPC=0xBFC0_0100, ExcCode=0x08, EXL=1.
- Delay-slot Ov then nested exception:
  - i_except=7'h40, i_bd=1, i_pc=0x8000_0014 → EPC=0x8000_0010, Cause.BD=1.
  - Second exception with EXL=1 → EPC unchanged.
- eret with EPC=0x8000_0040 → o_flush=1, o_new_pc=0x8000_0040; EXL=0 next cycle.
- Timer (CP0_TIMER_EN defined):
  - Write Count=0, Compare=5, Status=0x0000_8001 → TI after 10–11 cycles.
  - Interrupt taken only on a cycle with i_pc!=0; ExcCode=0.
  - Write Compare clears TI.
- Simultaneous mtc0 Status and AdES (i_except=7'h04, i_badvaddr=0x8000_0003) → Status write dropped, BadVAddr=0x8000_0003, ExcCode=0x05.
